dump_stream_arbiter: RTL and testbench



---
 rtl/dump_stream_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_dump_stream_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_stream_arbiter.sv
// -----------------------------------------------------------------------------
// dump_stream_arbiter
//   Shares one result-dump writer between NUM_CH free-running channels. Each
//   channel owns a one-entry holding register; a round-robin arbiter drains
//   the holds into a single (wr_en, wr_data, wr_chan) stream. A capture-window
//   FSM discards the first cfg_skip granted words, emits exactly cfg_len
//   words, then raises done.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cfg_start  one-cycle pulse: (re)arm a capture, latch cfg_skip/cfg_len
//   cfg_skip   granted words to discard before capturing
//   cfg_len    words to emit
//   ch_valid   per-channel sample strobe
//   ch_data    packed signed samples, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_ready   per-channel accept (combinational)
//   wr_en      one-cycle write strobe
//   wr_data    sample to write (holds last value when wr_en is low)
//   wr_chan    source channel of wr_data
//   busy       high while skipping or capturing
//   done       high once the capture window has closed
//   overflow   sticky per-channel dropped-sample flag
// -----------------------------------------------------------------------------
module dump_stream_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 24,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic [CNT_WIDTH-1:0]           cfg_skip,
    input  logic [CNT_WIDTH-1:0]           cfg_len,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    output logic [NUM_CH-1:0]              ch_ready,
    output logic                           wr_en,
    output logic signed [DATA_WIDTH-1:0]   wr_data,
    output logic [CH_W-1:0]                wr_chan,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_CH-1:0]              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [NUM_CH-1:0]             hold_full_r;
    logic signed [DATA_WIDTH-1:0]  hold_data_r [NUM_CH];
    logic [CNT_WIDTH-1:0]          skip_cnt_r;
    logic [CNT_WIDTH-1:0]          len_cnt_r;
    logic [CH_W-1:0]               rr_ptr_r;

    logic                          active_s;
    logic                          gnt_vld_s;
    logic [CH_W-1:0]               gnt_idx_s;
    logic [NUM_CH-1:0]             grant_s;
    logic [CH_W-1:0]               rr_next_s;
    logic [NUM_CH-1:0]             accept_s;
    logic [NUM_CH-1:0]             drop_s;
    logic                          next_active_s;

    assign active_s      = (state_r == ST_SKIP) || (state_r == ST_CAPTURE);
    assign next_active_s = (state_next_s == ST_SKIP) || (state_next_s == ST_CAPTURE);

    // Round-robin search over full holds starting at rr_ptr_r; a restart
    // cycle grants nothing because the holds are being flushed.
    always_comb begin
        logic [CH_W:0] sum;
        logic [CH_W-1:0] idx;
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        grant_s   = '0;
        sum       = '0;
        idx       = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            sum = {1'b0, rr_ptr_r} + (CH_W+1)'(off);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end else begin
                sum = sum;
            end
            idx = sum[CH_W-1:0];
            if (!gnt_vld_s && hold_full_r[idx] && active_s && !cfg_start) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = idx;
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
        if (gnt_vld_s) begin
            grant_s[gnt_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Pointer moves to the channel after the winner, wrapping at NUM_CH.
    always_comb begin
        if (gnt_idx_s == CH_W'(NUM_CH - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = gnt_idx_s + CH_W'(1);
        end
    end

    // Ready is combinational so a granted hold can be refilled in the same
    // cycle; outside the window samples are accepted and thrown away.
    always_comb begin
        if (active_s) begin
            ch_ready = ~hold_full_r | grant_s;
        end else begin
            ch_ready = {NUM_CH{1'b1}};
        end
        accept_s = ch_valid & ch_ready;
        if (active_s && !cfg_start) begin
            drop_s = ch_valid & ~ch_ready;
        end else begin
            drop_s = '0;
        end
    end

    // Capture-window next-state logic; cfg_start overrides everything.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_IDLE;
            end
            ST_SKIP: begin
                if (gnt_vld_s && (skip_cnt_r <= CNT_WIDTH'(1))) begin
                    if (len_cnt_r == CNT_WIDTH'(0)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CAPTURE;
                    end
                end else begin
                    state_next_s = ST_SKIP;
                end
            end
            ST_CAPTURE: begin
                if (gnt_vld_s && (len_cnt_r <= CNT_WIDTH'(1))) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (cfg_start) begin
            if (cfg_skip != CNT_WIDTH'(0)) begin
                state_next_s = ST_SKIP;
            end else if (cfg_len != CNT_WIDTH'(0)) begin
                state_next_s = ST_CAPTURE;
            end else begin
                state_next_s = ST_DONE;
            end
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register with busy/done registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= next_active_s;
            done    <= (state_next_s == ST_DONE);
        end
    end

    // Skip/length counters: loaded on start, decremented per grant, never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt_r <= '0;
            len_cnt_r  <= '0;
        end else if (cfg_start) begin
            skip_cnt_r <= cfg_skip;
            len_cnt_r  <= cfg_len;
        end else begin
            if (gnt_vld_s && (state_r == ST_SKIP) && (skip_cnt_r != CNT_WIDTH'(0))) begin
                skip_cnt_r <= skip_cnt_r - CNT_WIDTH'(1);
            end
            if (gnt_vld_s && (state_r == ST_CAPTURE) && (len_cnt_r != CNT_WIDTH'(0))) begin
                len_cnt_r <= len_cnt_r - CNT_WIDTH'(1);
            end
        end
    end

    // Round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (cfg_start) begin
            rr_ptr_r <= '0;
        end else if (gnt_vld_s) begin
            rr_ptr_r <= rr_next_s;
        end
    end

    // Holding registers: flushed on restart or when the window closes;
    // an accept wins over a grant so back-to-back samples are not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_data_r[i] <= '0;
            end
        end else if (cfg_start || !next_active_s) begin
            hold_full_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept_s[i]) begin
                    hold_full_r[i] <= 1'b1;
                    hold_data_r[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (grant_s[i]) begin
                    hold_full_r[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= '0;
        end else if (cfg_start) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | drop_s;
        end
    end

    // Writer outputs: only capture-phase grants produce a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
            wr_chan <= '0;
        end else if (gnt_vld_s && (state_r == ST_CAPTURE)) begin
            wr_en   <= 1'b1;
            wr_data <= hold_data_r[gnt_idx_s];
            wr_chan <= gnt_idx_s;
        end else begin
            wr_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dump_stream_arbiter.sv
module tb_dump_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 10;
    localparam int CW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_start;
    logic [CW-1:0]   cfg_skip;
    logic [CW-1:0]   cfg_len;
    logic [N-1:0]    ch_valid;
    logic [N*DW-1:0] ch_data;
    logic [N-1:0]    ch_ready;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [1:0]      wr_chan;
    logic            busy;
    logic            done;
    logic [N-1:0]    overflow;

    int n_checks = 0;
    int n_err    = 0;

    dump_stream_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_skip(cfg_skip),
        .cfg_len(cfg_len), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .wr_en(wr_en), .wr_data(wr_data),
        .wr_chan(wr_chan), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 discarding, 2 capturing, 3 finished
    int       m_mode;
    bit       m_full [N];
    int       m_hold [N];
    int       m_ptr, m_skip, m_len;
    bit [N-1:0] m_ovf;
    bit       e_wr_en;
    int       e_chan, e_data;
    int       wq[$];

    function automatic void model_reset();
        m_mode = 0; m_ptr = 0; m_skip = 0; m_len = 0; m_ovf = '0;
        e_wr_en = 1'b0; e_chan = 0; e_data = 0;
        for (int i = 0; i < N; i++) begin m_full[i] = 1'b0; m_hold[i] = 0; end
    endfunction

    function automatic void model_step();
        int g;
        g = -1;
        e_wr_en = 1'b0;
        if (cfg_start) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_ovf = '0; m_ptr = 0;
            m_skip = int'(cfg_skip); m_len = int'(cfg_len);
            m_mode = (m_skip != 0) ? 1 : ((m_len != 0) ? 2 : 3);
        end else if (m_mode == 1 || m_mode == 2) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && m_full[i]) g = i;
            end
            if (g >= 0 && m_mode == 2) begin
                e_wr_en = 1'b1; e_chan = g; e_data = m_hold[g];
            end
            for (int i = 0; i < N; i++) begin
                if (ch_valid[i]) begin
                    if (!m_full[i] || i == g) begin
                        m_full[i] = 1'b1;
                        m_hold[i] = int'(ch_data[i*DW +: DW]);
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end else if (i == g) begin
                    m_full[i] = 1'b0;
                end
            end
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (m_mode == 1) begin
                    m_skip = m_skip - 1;
                    if (m_skip == 0) m_mode = (m_len > 0) ? 2 : 3;
                end else begin
                    m_len = m_len - 1;
                    if (m_len == 0) m_mode = 3;
                end
            end
            if (m_mode == 3) for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        end
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic compare_model();
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        chk("wr_chan", 32'(wr_chan), 32'(e_chan));
        chk("wr_data", 32'(wr_data), 32'(e_data));
        chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
        chk("done", 32'(done), 32'(m_mode == 3));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (wr_en === 1'b1) wq.push_back(int'(wr_chan));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk); #1;
        compare_model();
    endtask

    task automatic start(input int skip, input int len);
        cfg_skip = 24'(skip); cfg_len = 24'(len); cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
    endtask

    task automatic set_data(input int t);
        for (int i = 0; i < N; i++) ch_data[i*DW +: DW] = 10'(i * 100 + t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        bit       start;
        int       skip;
        int       len;
        bit [3:0] valid;
        int       d2;
        bit       x_wr;
        int       x_chan;
        int       x_data;
        bit       x_busy;
        bit       x_done;
        bit [3:0] x_ovf;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int t;
        tbl[0] = '{1'b1, 0, 5, 4'b0100, 200, 1'b0, 0, 0,   1'b1, 1'b0, 4'b0000};
        tbl[1] = '{1'b0, 0, 0, 4'b0100, 201, 1'b0, 0, 0,   1'b1, 1'b0, 4'b0000};
        tbl[2] = '{1'b0, 0, 0, 4'b0100, 202, 1'b1, 2, 201, 1'b1, 1'b0, 4'b0000};
        tbl[3] = '{1'b0, 0, 0, 4'b0100, 203, 1'b1, 2, 202, 1'b1, 1'b0, 4'b0000};
        tbl[4] = '{1'b0, 0, 0, 4'b0100, 204, 1'b1, 2, 203, 1'b1, 1'b0, 4'b0000};
        tbl[5] = '{1'b0, 0, 0, 4'b0100, 205, 1'b1, 2, 204, 1'b1, 1'b0, 4'b0000};
        tbl[6] = '{1'b0, 0, 0, 4'b0100, 206, 1'b1, 2, 205, 1'b0, 1'b1, 4'b0000};
        tbl[7] = '{1'b0, 0, 0, 4'b0100, 207, 1'b0, 2, 205, 1'b0, 1'b1, 4'b0000};
        tbl[8] = '{1'b1, 0, 0, 4'b0100, 208, 1'b0, 2, 205, 1'b0, 1'b1, 4'b0000};
        tbl[9] = '{1'b0, 0, 0, 4'b0100, 209, 1'b0, 2, 205, 1'b0, 1'b1, 4'b0000};

        rst = 1'b1; cfg_start = 1'b0; cfg_skip = '0; cfg_len = '0;
        ch_valid = '0; ch_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(ch_ready), 32'hF);
        rst = 1'b0;

        // Single-channel capture and zero-length capture, from the table.
        for (int r = 0; r < 10; r++) begin
            cfg_start = tbl[r].start;
            cfg_skip  = 24'(tbl[r].skip);
            cfg_len   = 24'(tbl[r].len);
            ch_valid  = tbl[r].valid;
            ch_data   = '0;
            ch_data[2*DW +: DW] = 10'(tbl[r].d2);
            @(posedge clk); #1;
            chk("tbl_wr_en", 32'(wr_en), 32'(tbl[r].x_wr));
            chk("tbl_wr_chan", 32'(wr_chan), 32'(tbl[r].x_chan));
            chk("tbl_wr_data", 32'(wr_data), 32'(tbl[r].x_data));
            chk("tbl_busy", 32'(busy), 32'(tbl[r].x_busy));
            chk("tbl_done", 32'(done), 32'(tbl[r].x_done));
            chk("tbl_overflow", 32'(overflow), 32'(tbl[r].x_ovf));
        end
        cfg_start = 1'b0; ch_valid = '0;

        // All channels saturated: fair rotation, overflow on every channel.
        do_reset();
        wq.delete();
        t = 0;
        ch_valid = 4'hF; set_data(t);
        start(0, 8);
        repeat (12) begin t++; set_data(t); cycle(); end
        chk("rr_count", 32'(wq.size()), 32'd8);
        for (int i = 0; i < 8 && i < wq.size(); i++) chk("rr_chan", 32'(wq[i]), 32'(i % 4));
        chk("rr_done", 32'(done), 32'd1);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_ovf", 32'(overflow), 32'hF);

        // Skip window: six discarded grants, then channels 0,1,0.
        do_reset();
        wq.delete();
        ch_valid = 4'b0011; set_data(0);
        start(6, 3);
        for (int k = 1; k <= 14; k++) begin set_data(k); cycle(); end
        chk("skip_count", 32'(wq.size()), 32'd3);
        if (wq.size() == 3) begin
            chk("skip_chan0", 32'(wq[0]), 32'd0);
            chk("skip_chan1", 32'(wq[1]), 32'd1);
            chk("skip_chan2", 32'(wq[2]), 32'd0);
        end

        // Restart mid-capture after two words.
        do_reset();
        wq.delete();
        ch_valid = 4'hF; set_data(0);
        start(0, 4);
        for (int k = 1; k <= 30 && wq.size() < 2; k++) begin set_data(k); cycle(); end
        chk("restart_reach2", 32'(wq.size()), 32'd2);
        wq.delete();
        start(0, 4);
        chk("restart_ovf_clr", 32'(overflow), 32'd0);
        for (int k = 40; k < 52; k++) begin set_data(k); cycle(); end
        chk("restart_count", 32'(wq.size()), 32'd4);
        chk("restart_done", 32'(done), 32'd1);

        // Asynchronous reset while holds are full.
        do_reset();
        ch_valid = 4'hF; set_data(0);
        start(0, 20);
        for (int k = 1; k <= 5; k++) begin set_data(k); cycle(); end
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_wr_chan", 32'(wr_chan), 32'd0);
        chk("arst_wr_data", 32'(wr_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        wq.delete();
        for (int k = 6; k < 14; k++) begin set_data(k); cycle(); end
        chk("arst_no_wr", 32'(wq.size()), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            ch_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) ch_data[i*DW +: DW] = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 24) == 0 || (m_mode == 3 && $urandom_range(0, 3) == 0)
                || m_mode == 0) begin
                cfg_skip  = 24'($urandom_range(0, 5));
                cfg_len   = 24'($urandom_range(0, 12));
                cfg_start = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
            cycle();
        end
        cfg_start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
